// File: rtl/wb_pkg.sv
// ============================================================================
// wb_pkg: shared Wishbone widths and block-reader FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int WB_DW    = 32;
  localparam int WB_SEL_W = 4;
  localparam logic [WB_SEL_W-1:0] WB_SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FIN  = 2'd3
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_block_reader.sv
// ============================================================================
// wb_block_reader: Wishbone classic initiator streaming LEN words from BASE
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_block_reader
  import wb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WB_DW-1:0]    m_data,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [AW-1:0]       adr_o,
  output logic [WB_DW-1:0]    dat_o,
  output logic [WB_SEL_W-1:0] sel_o,
  input  logic                ack_i,
  input  logic [WB_DW-1:0]    dat_i
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT);

  wb_state_e state, state_nxt;

  logic [AW-1:0]    addr;
  logic [LEN_W-1:0] remaining;
  logic [TW-1:0]    tcnt;
  logic             accept, issue, ack_hit, expire, fin_go, drain;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    ack_hit   = 1'b0;
    expire    = 1'b0;
    fin_go    = 1'b0;
    drain     = m_valid && m_ready;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = (len == '0) ? FIN : REQ;
      end
      // The single output slot must be free (or freeing) before the next fetch.
      REQ: if (!m_valid || m_ready) begin
        issue     = 1'b1;
        state_nxt = WAIT;
      end
      // Ack has priority over a timeout expiring in the same cycle.
      WAIT: if (ack_i) begin
        ack_hit   = 1'b1;
        state_nxt = (remaining == LEN_W'(1)) ? FIN : REQ;
      end else if (TIMEOUT != 0 && tcnt == TW'(1)) begin
        expire    = 1'b1;
        state_nxt = FIN;
      end
      FIN: if (!m_valid) begin
        fin_go    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      tcnt      <= '0;
      cyc_o     <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= fin_go;
      if (accept) begin
        addr      <= base_addr;
        remaining <= len;
        err       <= 1'b0;
        busy      <= 1'b1;
      end
      if (fin_go) busy <= 1'b0;

      if (issue) begin
        cyc_o <= 1'b1;
        tcnt  <= TO_LOAD;
      end else if (state == WAIT && !ack_i && !expire) begin
        tcnt  <= tcnt - TW'(1);
      end
      if (ack_hit || expire) cyc_o <= 1'b0;
      if (expire) err <= 1'b1;

      if (ack_hit) begin
        m_data    <= dat_i;
        addr      <= addr + AW'(1);
        remaining <= remaining - LEN_W'(1);
      end
      if (ack_hit)    m_valid <= 1'b1;
      else if (drain) m_valid <= 1'b0;
    end
  end

  assign stb_o = cyc_o;
  assign adr_o = addr;
  assign we_o  = 1'b0;
  assign dat_o = '0;
  assign sel_o = WB_SEL_ALL;

endmodule

`default_nettype wire

// File: tb/tb_wb_block_reader.sv
// ============================================================================
// tb_wb_block_reader: randomized + directed bench against a queue-based model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_block_reader;
  import wb_pkg::*;

  localparam int AW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, busy, done, err, m_valid, m_ready;
  logic [31:0] base_addr, m_data, adr_o, dat_o, dat_i;
  logic [15:0] len;
  logic        cyc_o, stb_o, we_o, ack_i;
  logic [3:0]  sel_o;

  wb_block_reader #(.AW(AW), .LEN_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .err(err), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .sel_o(sel_o), .ack_i(ack_i), .dat_i(dat_i)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {16'hC0DE, a[15:0] * 16'd3};
  endfunction

  // ---------------- slave: registered self-clearing ack, or zero-wait ----------------
  bit fast = 0, slow = 0, noack = 0;
  int force_lat = -1;
  logic        ack_r;
  logic [31:0] dat_r;
  int wcnt, lat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0; dat_r <= '0; wcnt <= 0; lat <= 0;
    end else begin
      ack_r <= 1'b0;
      dat_r <= $urandom;
      if (stb_o && !ack_r && !noack && !fast) begin
        if (wcnt >= lat) begin
          ack_r <= 1'b1; dat_r <= rom(adr_o); wcnt <= 0;
        end else wcnt <= wcnt + 1;
      end else if (!stb_o) begin
        wcnt <= 0;
        lat  <= (force_lat >= 0) ? force_lat : (slow ? int'($urandom_range(0, 3)) : 0);
      end
    end
  end
  assign ack_i = fast ? stb_o : ack_r;
  assign dat_i = fast ? (stb_o ? rom(adr_o) : 32'hDEAD_BEEF) : dat_r;

  bit ready_rand = 0;
  always @(posedge clk) begin
    #1;
    if (ready_rand) m_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- model state ----------------
  logic [31:0] exp_d[$], exp_a[$], seen_d[$], seen_a[$];
  bit   cmd_active = 0, exp_err = 0, chk_rate = 0, first_rise = 0;
  int   cyc_cnt = 0, acc_cyc = 0, cur_len = 0, stb_run = 0, last_rise = -1, n_tmo = 0;
  logic p_valid = 0, p_ready = 0, p_stb = 0, p_ack = 0;
  logic [31:0] p_data = 0, p_adr = 0, cmp_v = 0;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 0; p_ready = 0; p_stb = 0; p_ack = 0; stb_run = 0;
    end else begin
      chk(stb_o == cyc_o && !we_o && dat_o == 0 && sel_o == 4'hF, "bus_static",
          {cyc_o, stb_o, we_o, sel_o}, {cyc_o, cyc_o, 1'b0, 4'hF});
      chk(busy == (cmd_active && !done), "busy", busy, cmd_active && !done);
      if (!cmd_active) chk(err == exp_err, "err_idle", err, exp_err);

      if (stb_o && !p_stb) begin
        seen_a.push_back(adr_o);
        if (exp_a.size() == 0) chk(0, "adr_extra_stb", adr_o, 0);
        else begin cmp_v = exp_a.pop_front(); chk(adr_o == cmp_v, "adr", adr_o, cmp_v); end
        chk(!(p_valid && !p_ready), "stb_while_full", p_valid, 0);
        chk(!p_ack, "stb_after_ack", p_ack, 0);
        if (first_rise) begin
          chk(cyc_cnt - acc_cyc == 2, "start_to_stb", cyc_cnt - acc_cyc, 2);
          first_rise = 0;
        end
        if (chk_rate && last_rise >= 0) chk(cyc_cnt - last_rise == 2, "rate", cyc_cnt - last_rise, 2);
        last_rise = cyc_cnt;
      end
      if (stb_o && p_stb) chk(adr_o == p_adr, "adr_stable", adr_o, p_adr);
      if (stb_o) stb_run++;
      else if (p_stb) begin
        if (!p_ack) begin
          n_tmo++;
          chk(stb_run == TMO, "timeout_len", stb_run, TMO);
        end
        stb_run = 0;
      end

      if (p_valid && !p_ready) chk(m_valid && m_data == p_data, "hold", m_data, p_data);
      if (m_valid && m_ready) begin
        seen_d.push_back(m_data);
        if (exp_d.size() == 0) chk(0, "data_extra", m_data, 0);
        else begin cmp_v = exp_d.pop_front(); chk(m_data == cmp_v, "data", m_data, cmp_v); end
      end

      if (done) begin
        chk(cmd_active, "done_spurious", 0, 1);
        chk(exp_d.size() == 0 && exp_a.size() == 0, "words_left", exp_d.size() + exp_a.size(), 0);
        chk(err == exp_err, "err_done", err, exp_err);
        if (cur_len == 0) chk(cyc_cnt - acc_cyc == 2, "len0_done_lat", cyc_cnt - acc_cyc, 2);
        cmd_active = 0;
      end

      p_valid = m_valid; p_ready = m_ready; p_data = m_data;
      p_stb = stb_o; p_adr = adr_o; p_ack = ack_i && stb_o;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic issue(input logic [31:0] b, input int l);
    @(posedge clk); #1;
    base_addr = b; len = 16'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; len = 16'($urandom);
    cur_len = l; acc_cyc = cyc_cnt - 1; first_rise = 1; last_rise = -1;
    exp_err = noack && (l > 0);
    if (l > 0) begin
      if (noack) exp_a.push_back(b);
      else for (int i = 0; i < l; i++) begin
        exp_a.push_back(b + 32'(i));
        exp_d.push_back(rom(b + 32'(i)));
      end
    end
    cmd_active = 1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (cmd_active && n < 3000) begin @(posedge clk); #1; n++; end
    if (cmd_active) begin
      chk(0, "done_never_came", n, 0);
      cmd_active = 0;
    end
  endtask

  // ---------------- AW=4 instance for address wrap ----------------
  logic        start4, busy4, done4, err4, mv4, mr4, cyc4, stb4, we4, ack4;
  logic [3:0]  ba4, adr4, sel4;
  logic [15:0] len4;
  logic [31:0] md4, do4, di4;

  wb_block_reader #(.AW(4), .LEN_W(16), .TIMEOUT(TMO)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .base_addr(ba4), .len(len4),
    .busy(busy4), .done(done4), .err(err4), .m_valid(mv4), .m_ready(mr4),
    .m_data(md4), .cyc_o(cyc4), .stb_o(stb4), .we_o(we4), .adr_o(adr4),
    .dat_o(do4), .sel_o(sel4), .ack_i(ack4), .dat_i(di4)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin ack4 <= 1'b0; di4 <= '0; end
    else begin ack4 <= stb4 && !ack4; di4 <= rom({28'h0, adr4}); end
  end

  logic [3:0]  a4[$];
  logic [31:0] d4[$];
  logic        p_stb4 = 0;
  always @(negedge clk) begin
    if (!rst_n) p_stb4 = 0;
    else begin
      if (stb4 && !p_stb4) a4.push_back(adr4);
      if (mv4 && mr4) d4.push_back(md4);
      p_stb4 = stb4;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] exp4 [4];
    int n, sz, szd, tmo0;
    exp4 = '{4'hE, 4'hF, 4'h0, 4'h1};
    start = 0; base_addr = 0; len = 0; m_ready = 1;
    start4 = 0; ba4 = 0; len4 = 0; mr4 = 1;

    repeat (2) @(posedge clk); #1;
    chk({busy, done, err, m_valid, cyc_o, stb_o} == 6'b0, "reset_ctrl",
        {busy, done, err, m_valid, cyc_o, stb_o}, 0);
    chk(adr_o == 0 && m_data == 0, "reset_data", {adr_o, m_data}, 0);
    chk(sel_o == 4'hF, "reset_sel", sel_o, 4'hF);
    @(negedge clk); rst_n = 1;

    // address wrap on a 4-bit bus
    @(posedge clk); #1; ba4 = 4'hE; len4 = 16'd4; start4 = 1;
    @(posedge clk); #1; start4 = 0;
    n = 0;
    while (!done4 && n < 200) begin @(posedge clk); #1; n++; end
    chk(done4 && !err4, "aw4_done", {done4, err4}, 2'b10);
    chk(a4.size() == 4 && d4.size() == 4, "aw4_count", a4.size() * 16 + d4.size(), 8'h44);
    for (int i = 0; i < 4; i++)
      if (i < a4.size() && i < d4.size()) begin
        chk(a4[i] == exp4[i], "aw4_adr", a4[i], exp4[i]);
        chk(d4[i] == rom({28'h0, exp4[i]}), "aw4_data", d4[i], rom({28'h0, exp4[i]}));
      end

    // four words from 0x10, registered-ack slave
    seen_a.delete(); seen_d.delete();
    issue(32'h10, 4); wait_done();
    chk(seen_a.size() == 4 && seen_d.size() == 4, "t1_count", seen_a.size() * 16 + seen_d.size(), 8'h44);
    if (seen_a.size() == 4 && seen_d.size() == 4) begin
      chk(seen_a[0] == 32'h10 && seen_a[3] == 32'h13, "t1_adr_lit", {seen_a[0], seen_a[3]}, {32'h10, 32'h13});
      chk(seen_d[0] == 32'hC0DE0030, "t1_d0_lit", seen_d[0], 32'hC0DE0030);
      chk(seen_d[3] == 32'hC0DE0039, "t1_d3_lit", seen_d[3], 32'hC0DE0039);
    end

    // same command against a zero-wait slave: one word every 2 cycles
    fast = 1; chk_rate = 1;
    issue(32'h10, 4); wait_done();
    fast = 0; chk_rate = 0;

    // consumer stalls after the first word
    m_ready = 0; sz = seen_a.size(); szd = seen_d.size();
    issue(32'h100, 3);
    n = 0;
    while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk(m_valid, "t2_first_word", m_valid, 1);
    repeat (10) @(posedge clk);
    #1 chk(seen_a.size() - sz == 1, "t2_one_stb_stall", seen_a.size() - sz, 1);
    m_ready = 1;
    wait_done();
    chk(seen_d.size() - szd == 3, "t2_words", seen_d.size() - szd, 3);

    // zero-length command
    issue(32'h55, 0); wait_done();

    // slave never acks
    noack = 1; tmo0 = n_tmo;
    issue(32'h20, 2); wait_done();
    chk(n_tmo - tmo0 == 1, "t4_one_timeout", n_tmo - tmo0, 1);
    noack = 0;
    issue(32'h30, 1);
    @(negedge clk); #1 chk(!err, "t4_err_cleared", err, 0);
    wait_done();

    // ack arrives in the very cycle the timeout would expire
    force_lat = 6;
    issue(32'h60, 2); wait_done();
    force_lat = -1;

    // reset mid-WAIT, then a start while busy
    issue(32'h40, 5);
    n = 0;
    while (!stb_o && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk({cyc_o, stb_o, m_valid, busy, done} == 5'b0, "t6_reset_async",
        {cyc_o, stb_o, m_valid, busy, done}, 0);
    chk(adr_o == 0, "t6_reset_adr", adr_o, 0);
    exp_a.delete(); exp_d.delete(); cmd_active = 0; exp_err = 0;
    @(posedge clk); #1 rst_n = 1;
    issue(32'h80, 6);
    repeat (3) @(posedge clk);
    #1 base_addr = 32'h1234; len = 16'd2; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done();

    // randomized commands, random ready and slave latency
    slow = 1; ready_rand = 1;
    for (int k = 0; k < 25; k++) begin
      noack = ($urandom_range(0, 7) == 0);
      issue((k % 5 == 0) ? 32'hFFFF_FFFE : 32'($urandom), $urandom_range(0, 5));
      wait_done();
    end
    noack = 0; slow = 0; ready_rand = 0;
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
